// File: rtl/adc.sv
// Behavioural 8-bit successive-approximation ADC. Each accepted request samples an
// internal triangle-wave generator and resolves one result bit per clock, MSB first.
module adc #(
  parameter int STEP        = 16,
  parameter int INIT_SAMPLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       rdy,
  output logic [7:0] dat
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;
  localparam logic       DIR_UP   = 1'b0;
  localparam logic       DIR_DOWN = 1'b1;

  localparam logic [7:0] STEP_B = 8'(STEP);
  localparam logic [7:0] INIT_B = 8'(INIT_SAMPLE);
  localparam logic [7:0] UP_LIM = 8'(255 - STEP);

  logic [0:0] state_q, state_d;
  logic       req_prev_q, req_prev_d;
  logic       rdy_q, rdy_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] wave_q, wave_d;
  logic       dir_q, dir_d;
  logic [7:0] sar_q, sar_d;
  logic [7:0] held_q, held_d;
  logic [2:0] idx_q, idx_d;

  logic       start;
  logic [7:0] trial;

  assign start = req & ~req_prev_q;
  assign trial = sar_q | (8'd1 << idx_q);

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    state_d    = state_q;
    req_prev_d = req;
    rdy_d      = rdy_q;
    dat_d      = dat_q;
    wave_d     = wave_q;
    dir_d      = dir_q;
    sar_d      = sar_q;
    held_d     = held_q;
    idx_d      = idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          held_d  = wave_q;
          sar_d   = 8'd0;
          idx_d   = 3'd7;
          rdy_d   = 1'b0;
          state_d = CONVERT;
          // Generator saturates at the rails and reverses instead of wrapping.
          if (dir_q == DIR_UP) begin
            if (wave_q > UP_LIM) begin
              wave_d = 8'd255;
              dir_d  = DIR_DOWN;
            end else begin
              wave_d = wave_q + STEP_B;
            end
          end else begin
            if (wave_q < STEP_B) begin
              wave_d = 8'd0;
              dir_d  = DIR_UP;
            end else begin
              wave_d = wave_q - STEP_B;
            end
          end
        end
      end
      default: begin
        // A start seen here is dropped on purpose: requests are never queued.
        if (trial <= held_q) sar_d = trial;
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          dat_d   = sar_d;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b0;
      rdy_q      <= 1'b0;
      dat_q      <= 8'd0;
      wave_q     <= INIT_B;
      dir_q      <= DIR_UP;
      sar_q      <= 8'd0;
      held_q     <= 8'd0;
      idx_q      <= 3'd7;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      rdy_q      <= rdy_d;
      dat_q      <= dat_d;
      wave_q     <= wave_d;
      dir_q      <= dir_d;
      sar_q      <= sar_d;
      held_q     <= held_d;
      idx_q      <= idx_d;
    end
  end

  assign rdy = rdy_q;
  assign dat = dat_q;

endmodule

// File: tb/tb_adc.sv
// Directed bench for adc: reset, latency, triangle sequence, request filtering,
// mid-conversion reset and a second parameterisation.
module tb_adc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req1 = 1'b0;
  logic       req2 = 1'b0;
  logic       rdy1, rdy2;
  logic [7:0] dat1, dat2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc u_dut (
    .clk (clk),
    .rst (rst),
    .req (req1),
    .rdy (rdy1),
    .dat (dat1)
  );

  adc #(.STEP(100), .INIT_SAMPLE(50)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .req (req2),
    .rdy (rdy2),
    .dat (dat2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input bit sel);
    return sel ? rdy2 : rdy1;
  endfunction

  function automatic logic [7:0] get_dat(input bit sel);
    return sel ? dat2 : dat1;
  endfunction

  task automatic set_req(input bit sel, input logic v);
    if (sel) req2 = v;
    else     req1 = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; the following posedge is the start edge N.
  task automatic conv(input bit sel, input logic [7:0] exp, input string tag);
    set_req(sel, 1'b1);
    @(negedge clk);
    set_req(sel, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, {7'd0, get_rdy(sel)}, 8'd0);
      @(negedge clk);
    end
    check({tag, "_rdy"}, {7'd0, get_rdy(sel)}, 8'd1);
    check({tag, "_dat"}, get_dat(sel), exp);
  endtask

  logic [7:0] seq_exp [20] = '{8'd0, 8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd112,
                               8'd128, 8'd144, 8'd160, 8'd176, 8'd192, 8'd208, 8'd224,
                               8'd240, 8'd255, 8'd239, 8'd223, 8'd207};
  logic [7:0] par_exp [8]  = '{8'd50, 8'd150, 8'd250, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};

  initial begin
    int   rises;
    logic prev;

    // Reset state, including an asynchronous assertion between edges.
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rdy", {7'd0, rdy1}, 8'd0);
    check("rst_async_dat", dat1, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle_rdy", {7'd0, rdy1}, 8'd0);

    // Single conversion then a long idle hold.
    conv(1'b0, 8'd0, "single");
    repeat (20) @(negedge clk);
    check("single_hold_rdy", {7'd0, rdy1}, 8'd1);
    check("single_hold_dat", dat1, 8'd0);

    // Twenty requests, 12 cycles apart, walking up and over the top rail.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      conv(1'b0, seq_exp[i], $sformatf("seq%0d", i));
      repeat (3) @(negedge clk);
    end

    // Async reset with a non-zero result on the outputs.
    #2 rst = 1'b1;
    #1;
    check("rst_after_seq_rdy", {7'd0, rdy1}, 8'd0);
    check("rst_after_seq_dat", dat1, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Held request: one conversion only.
    rises = 0;
    prev  = rdy1;
    req1  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rdy1 && !prev) rises++;
      prev = rdy1;
    end
    req1 = 1'b0;
    check("held_rises", 8'(rises), 8'd1);
    check("held_dat", dat1, 8'd0);
    @(negedge clk);

    // Pulse at edge N+3 of a running conversion must be dropped.
    rises = 0;
    req1  = 1'b1;
    @(negedge clk);
    req1  = 1'b0;
    prev  = rdy1;
    repeat (2) @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rdy1 && !prev) rises++;
      prev = rdy1;
    end
    check("overlap_rises", 8'(rises), 8'd1);
    check("overlap_rdy", {7'd0, rdy1}, 8'd1);
    check("overlap_dat", dat1, 8'd16);

    // Reset during the third conversion, just before edge N+4.
    do_reset();
    conv(1'b0, 8'd0, "mid_c1");
    repeat (3) @(negedge clk);
    conv(1'b0, 8'd16, "mid_c2");
    repeat (3) @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", {7'd0, rdy1}, 8'd0);
    check("mid_rst_dat", dat1, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_hold_rdy", {7'd0, rdy1}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    conv(1'b0, 8'd0, "mid_after");

    // Second parameterisation: STEP=100, INIT_SAMPLE=50.
    do_reset();
    check("par_rst_rdy", {7'd0, rdy2}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      conv(1'b1, par_exp[i], $sformatf("par%0d", i));
      repeat (3) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc.md
Name: adc

Overview:
- Synthesizable behavioural model of an 8-bit successive-approximation ADC, used as the data source for downstream sampling logic and benches.
- A request pulse makes it sample an internal deterministic "analog" stand-in, a triangle-wave generator.
- It resolves one bit per clock, then presents the 8-bit result with a ready flag.

Parameters:
- STEP, 16: triangle generator increment per sample (1..127).
- INIT_SAMPLE, 0: generator value after reset (0..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  1  conversion request; edge-detected, synchronous to clk.
- rdy  output 1  result valid; high from conversion end until next accepted request.
- dat  output 8  last conversion result, unsigned.

Behaviour:
- Reset (rst=1, async):
  - state=IDLE, rdy=0, dat=0, req_q=0.
  - wave=INIT_SAMPLE, dir=UP, sar=0, held=0, bit index=7.
- Request detect: start = req & ~req_q, evaluated at each rising edge. req_q<=req every cycle.
- Request rules:
  - A request held high starts only one conversion.
  - start while state=CONVERT is ignored and not queued.
- State IDLE, on start:
  - held<=wave, sar<=0, idx<=7, rdy<=0, state<=CONVERT.
  - dat keeps its old value.
  - The generator advances once in the same cycle.
- State CONVERT, each cycle:
  - trial = sar | (1<<idx); if trial <= held then sar bit idx<=1, else 0.
  - idx decrements.
  - After resolving idx 0: dat<=final sar (equals held), rdy<=1, state<=IDLE.
- Latency: start sampled at edge N, bits resolved at edges N+1..N+8, rdy=1 and dat valid after edge N+8. Next start is accepted no earlier than edge N+9.
- rdy stays 1 and dat stable indefinitely in IDLE. rdy drops on the edge accepting the next start.
- Triangle generator (advances only on accepted start):
  - UP: if wave > 255-STEP then wave<=255, dir<=DOWN; else wave<=wave+STEP.
  - DOWN: if wave < STEP then wave<=0, dir<=UP; else wave<=wave-STEP.
  - With STEP=16, INIT 0, successive results are: 0,16,32,…,240,255,239,223,…,15,0,16,…
- All arithmetic unsigned 8-bit with explicit saturation as above; no wrap-around.
- Reset mid-conversion aborts immediately to reset values. The first request after reset returns INIT_SAMPLE.
- No X on outputs at any time after reset.

Test Plan:
- Reset: assert rst=1 asynchronously mid-cycle -> rdy=0, dat=0 immediately without a clock edge. Release rst; rdy stays 0 with req=0.
- Single conversion: after reset, pulse req high across one rising edge -> rdy=0 for the following 8 edges, then rdy=1 and dat=0 after edge N+8; dat stays 0 and rdy stays 1 for 20 further cycles.
- Sequence: issue 20 requests spaced 12 cycles apart -> dat results 0,16,…,240,255,239,223,207 and rdy=1 before each next request.
- Held/overlapping request: hold req=1 for 30 cycles -> exactly one conversion, result 0. Then a 1-cycle req pulse at edge N+3 of a new conversion -> ignored; only one rdy rise, value 16.
- Reset mid-conversion: after the start of the 3rd conversion (held=32), assert rst at edge N+4 -> rdy=0, dat=0. Next request after release returns 0, not 48.
- Parameter check: STEP=100, INIT_SAMPLE=50 -> results 50,150,250,255,155,55,0,100.
